rlt_bcd_ascii_fmt: RTL and testbench
====================================

Name: rlt_bcd_ascii_fmt

Overview:
Sequential formatter sitting directly upstream of the LCD line-2 result buffer. It takes the calculator's 32-bit two's-complement result and converts it to decimal with an iterative shift-add-3 (double dabble) engine, one bit per clock. It then emits a right-justified 16-character ASCII line with a minus sign and blanked leading zeros. The LCD driver copies this line byte-for-byte into its line-2 register when result mode is selected.

Parameters:
WIDTH, 32, bit width of the signed input result.
DIGITS, 10, number of BCD digits; must cover 2^(WIDTH-1).
LCD_COLS, 16, characters per output line.

Ports:
clk  input  1  system clock (same domain as the LCD driver).
rst  input  1  synchronous, active-low reset.
start  input  1  one-cycle request to convert rlt_in.
rlt_in  input  WIDTH  signed result; sampled only on the edge where start is accepted.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse; line_ascii is valid from this cycle.
bcd_out  output  4*DIGITS  magnitude in BCD; digit 0 (units) is in bits [3:0].
neg_out  output  1  sign of the last converted result.
line_ascii  output  8*LCD_COLS  ASCII line; byte i is [8*i +: 8]; byte 0 is the leftmost column and byte LCD_COLS-1 the rightmost.

Behaviour:
- Reset (rst=0 at a clk edge):
  - busy=0, done=0, neg_out=0, bcd_out=0.
  - Every byte of line_ascii = 8'h20.
  - FSM goes to IDLE.
  - Reset during any state aborts the conversion; no done pulse is produced.
- FSM states: IDLE, ABS, SHIFT, FMT.
  - IDLE: start=1 latches rlt_in, sets busy=1, goes to ABS. start=0 keeps the FSM in IDLE.
  - ABS (1 cycle):
    - neg = rlt_in[WIDTH-1].
    - mag = neg ? (~rlt_in + 1) : rlt_in, as a WIDTH-bit unsigned value. -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) with no overflow.
    - Clear the BCD shift register and load bit counter = WIDTH-1. Go to SHIFT.
  - SHIFT (exactly WIDTH cycles):
    - Each cycle, every BCD nibble >= 5 first gets +3.
    - Then {bcd, mag} shifts left by 1, moving mag's MSB into bcd[0].
    - The counter decrements; at 0, go to FMT.
  - FMT (1 cycle):
    - Register bcd_out and neg_out.
    - Build line_ascii:
      - The units digit always lands in byte LCD_COLS-1 as 8'h30+digit.
      - Digit k goes to byte LCD_COLS-1-k.
      - Digits above the most significant nonzero digit become 8'h20.
      - If neg, 8'h2D goes in the byte immediately left of the most significant shown digit.
      - All remaining bytes are 8'h20.
    - Assert done for 1 cycle, clear busy, return to IDLE.
- Latency: start sampled at edge E0 → busy high after E0. line_ascii, bcd_out, neg_out and done update at edge E(WIDTH+2), which is E34 at default; busy falls at that same edge.
- start while busy is ignored; there is no queueing and the latched operand is unchanged.
- start in the cycle done is high is sampled in IDLE and accepted normally (back-to-back conversions, one every WIDTH+3 cycles).
- line_ascii, bcd_out and neg_out hold their values between conversions. They change only in FMT or on reset.
- Zero result: line shows a single '0' in the rightmost byte; no sign.
- Output widths never truncate: DIGITS+1 <= LCD_COLS is required. An elaboration-time check fails if it is violated.

Optional Feature:
RLT_PLUS_SIGN_EN
- Defined: strictly positive results get 8'h2B ('+') in the sign position, placed the same way as '-'. Zero stays unsigned.
- Undefined: positive results carry no sign character and the sign byte stays 8'h20.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- rlt_in=0, start pulse:
  - line_ascii = 15×8'h20 then "0".
  - done exactly 34 cycles after the start edge; bcd_out=0, neg_out=0.
- rlt_in=1234:
  - line = 12 blanks + "1234".
  - bcd_out[15:0]=16'h1234, neg_out=0.
  - With RLT_PLUS_SIGN_EN: 11 blanks + "+1234".
- rlt_in=-5 (32'hFFFFFFFB): line = 14 blanks + "-5", neg_out=1, bcd_out=5.
- Range limits, one conversion each:
  - rlt_in=32'h80000000 → 5 blanks + "-2147483648".
  - rlt_in=32'h7FFFFFFF → 6 blanks + "2147483647".
- Start while busy: start(1234), then start(99) 10 cycles later.
  - Exactly one done pulse, and the line shows "1234".
  - start(99) issued during the done cycle → second done 35 cycles later showing "99".
- Reset mid-operation: rst=0 during SHIFT.
  - Next cycle: busy=0, all bytes 8'h20, no done pulse.
  - A subsequent start(-42) completes normally with 13 blanks + "-42".

Source files
------------

// File: rtl/rlt_bcd_ascii_fmt.sv
// Result formatter: signed binary -> BCD (double dabble, one bit per clock) -> right-justified
// ASCII line for the LCD. Define RLT_PLUS_SIGN_EN to show '+' on strictly positive results.
module rlt_bcd_ascii_fmt #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 10,
  parameter int LCD_COLS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      rlt_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out,
  output logic [8*LCD_COLS-1:0] line_ascii
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS + 1 > LCD_COLS) begin : g_cols_check
    $error("rlt_bcd_ascii_fmt: DIGITS+1 must not exceed LCD_COLS");
  end

  typedef enum logic [1:0] {StIdle, StAbs, StShift, StFmt} state_e;

  state_e                r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_opnd;
  logic [WIDTH-1:0]      r_mag;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [CW-1:0]         r_cnt;
  logic                  r_neg;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd_out;
  logic                  r_neg_out;
  logic [8*LCD_COLS-1:0] r_line;

  logic                  w_load, w_abs, w_shift, w_fmt;
  logic                  w_neg;
  logic [WIDTH-1:0]      w_mag;
  logic [4*DIGITS-1:0]   w_bcd_adj;
  logic [DW-1:0]         w_msd;
  logic                  w_sign_en;
  logic [7:0]            w_sign_chr;
  logic [8*LCD_COLS-1:0] w_line;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = StAbs;
      StAbs:   w_state_nxt = StShift;
      StShift: if (r_cnt == '0) w_state_nxt = StFmt;
      StFmt:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    busy    = (r_state != StIdle);
    w_load  = (r_state == StIdle) && start;
    w_abs   = (r_state == StAbs);
    w_shift = (r_state == StShift);
    w_fmt   = (r_state == StFmt);
  end

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    w_neg = r_opnd[WIDTH-1];
    w_mag = w_neg ? (~r_opnd + WIDTH'(1)) : r_opnd;
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Index of the most significant nonzero digit (0 when the value is zero).
  always_comb begin
    w_msd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] != 4'd0) w_msd = DW'(k);
    end
  end

  always_comb begin
`ifdef RLT_PLUS_SIGN_EN
    w_sign_en  = r_neg || (r_bcd != '0);
`else
    w_sign_en  = r_neg;
`endif
    w_sign_chr = r_neg ? 8'h2D : 8'h2B;
  end

  always_comb begin
    w_line = {LCD_COLS{8'h20}};
    for (int k = 0; k < DIGITS; k++) begin
      if (k <= int'(w_msd)) w_line[8*(LCD_COLS-1-k) +: 8] = 8'h30 + {4'h0, r_bcd[4*k +: 4]};
      if (k == int'(w_msd) && w_sign_en) w_line[8*(LCD_COLS-2-k) +: 8] = w_sign_chr;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_opnd    <= '0;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
      r_neg_out <= 1'b0;
      r_line    <= {LCD_COLS{8'h20}};
    end else begin
      r_done <= 1'b0;
      if (w_load) r_opnd <= rlt_in;
      if (w_abs) begin
        r_neg <= w_neg;
        r_mag <= w_mag;
        r_bcd <= '0;
        r_cnt <= CW'(WIDTH-1);
      end
      if (w_shift) begin
        {r_bcd, r_mag} <= {w_bcd_adj[4*DIGITS-2:0], r_mag, 1'b0};
        r_cnt          <= r_cnt - CW'(1);
      end
      if (w_fmt) begin
        r_bcd_out <= r_bcd;
        r_neg_out <= r_neg;
        r_line    <= w_line;
        r_done    <= 1'b1;
      end
    end
  end

  assign done       = r_done;
  assign bcd_out    = r_bcd_out;
  assign neg_out    = r_neg_out;
  assign line_ascii = r_line;

endmodule

// File: tb/tb_rlt_bcd_ascii_fmt.sv
// Self-checking bench for rlt_bcd_ascii_fmt: fixed vector table, corner sequences and random
// operands checked against an integer-arithmetic reference model.
module tb_rlt_bcd_ascii_fmt;

  localparam int WIDTH    = 32;
  localparam int DIGITS   = 10;
  localparam int LCD_COLS = 16;
  localparam int LAT      = WIDTH + 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [WIDTH-1:0]      rlt_in = '0;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg_out;
  logic [8*LCD_COLS-1:0] line_ascii;

  int n_chk  = 0;
  int n_fail = 0;

  rlt_bcd_ascii_fmt #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .LCD_COLS (LCD_COLS)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rlt_in     (rlt_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .neg_out    (neg_out),
    .line_ascii (line_ascii)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    string       txt;
    logic [39:0] bcd;
    logic        neg;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Right-justify a string into a blank-filled line.
  function automatic logic [127:0] rj(input string s);
    logic [127:0] l;
    l = {LCD_COLS{8'h20}};
    for (int i = 0; i < s.len(); i++) l[8*(LCD_COLS - s.len() + i) +: 8] = s[i];
    return l;
  endfunction

  function automatic string pos(input string s);
`ifdef RLT_PLUS_SIGN_EN
    return {"+", s};
`else
    return s;
`endif
  endfunction

  // Reference: decimal digits by repeated division of the signed value's magnitude.
  function automatic void model(input logic [31:0] v, output logic [127:0] line,
                                output logic [39:0] bcd, output logic neg);
    longint sv, m;
    int     col, k;
    sv   = longint'($signed(v));
    neg  = (sv < 0);
    m    = neg ? -sv : sv;
    line = {LCD_COLS{8'h20}};
    bcd  = '0;
    col  = LCD_COLS - 1;
    k    = 0;
    do begin
      line[8*col +: 8] = 8'h30 + 8'(m % 10);
      bcd[4*k +: 4]    = 4'(m % 10);
      m                = m / 10;
      col--;
      k++;
    end while (m != 0);
    if (neg) line[8*col +: 8] = 8'h2D;
`ifdef RLT_PLUS_SIGN_EN
    else if (sv > 0) line[8*col +: 8] = 8'h2B;
`endif
  endfunction

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  // Start one conversion; lat is the number of edges from the start edge to the done edge.
  task automatic run_conv(input logic [31:0] v, output int lat);
    @(negedge clk);
    rlt_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rlt_in = $urandom;
    chk("busy_after_start", busy, 1'b1);
    wait_done(lat);
    if (lat > 0) begin
      chk("busy_at_done", busy, 1'b0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", done, 1'b0);
    end
  endtask

  initial begin
    int           lat, n2, dcount;
    logic [127:0] m_line;
    logic [39:0]  m_bcd;
    logic         m_neg;
    logic [31:0]  v;

    tbl[0] = '{32'd0,        "0",                  40'h0,          1'b0};
    tbl[1] = '{32'd1234,     pos("1234"),          40'h1234,       1'b0};
    tbl[2] = '{32'hFFFFFFFB, "-5",                 40'h5,          1'b1};
    tbl[3] = '{32'h80000000, "-2147483648",        40'h2147483648, 1'b1};
    tbl[4] = '{32'h7FFFFFFF, pos("2147483647"),    40'h2147483647, 1'b0};
    tbl[5] = '{32'd1000000000, pos("1000000000"),  40'h1000000000, 1'b0};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_neg", neg_out, 1'b0);
    chk("reset_bcd", bcd_out, 40'h0);
    chk("reset_line", line_ascii, {LCD_COLS{8'h20}});
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_conv(tbl[i].val, lat);
      chk($sformatf("tbl%0d_latency", i), lat, LAT);
      chk($sformatf("tbl%0d_line", i), line_ascii, rj(tbl[i].txt));
      chk($sformatf("tbl%0d_bcd", i), bcd_out, tbl[i].bcd);
      chk($sformatf("tbl%0d_neg", i), neg_out, tbl[i].neg);
    end

    // Start while busy is ignored, then a start during the done cycle is accepted.
    @(negedge clk);
    rlt_in = 32'd1234;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rlt_in = 32'd99;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rlt_in = '0;
    wait_done(lat);
    chk("busy_ignore_latency", lat, LAT - 10);
    chk("busy_ignore_line", line_ascii, rj(pos("1234")));
    rlt_in = 32'd99;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rlt_in = '0;
    chk("b2b_busy", busy, 1'b1);
    wait_done(n2);
    chk("b2b_period", n2 + 1, WIDTH + 3);
    chk("b2b_line", line_ascii, rj(pos("99")));
    chk("b2b_bcd", bcd_out, 40'h99);

    // Reset in the middle of SHIFT aborts without a done pulse.
    @(negedge clk);
    rlt_in = 32'd1234;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_line", line_ascii, {LCD_COLS{8'h20}});
    chk("midrst_bcd", bcd_out, 40'h0);
    dcount = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    run_conv(-32'sd42, lat);
    chk("after_rst_latency", lat, LAT);
    chk("after_rst_line", line_ascii, rj("-42"));
    chk("after_rst_neg", neg_out, 1'b1);

    // Random operands against the reference model.
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) v = 32'($urandom_range(0, 2000)) - 32'd1000;
      else            v = $urandom;
      model(v, m_line, m_bcd, m_neg);
      run_conv(v, lat);
      chk($sformatf("rnd%0d_latency(%h)", i, v), lat, LAT);
      chk($sformatf("rnd%0d_line(%h)", i, v), line_ascii, m_line);
      chk($sformatf("rnd%0d_bcd(%h)", i, v), bcd_out, m_bcd);
      chk($sformatf("rnd%0d_neg(%h)", i, v), neg_out, m_neg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
